pipeline_ctrl: RTL and testbench

Central stall/flush scheduler for the five-stage rv32i pipeline. Drives the `load` and bubble-insert controls of the PC register and the four `stage_latch` instances (IF/ID, ID/EX, EX/MEM, MEM/WB). It arbitrates between:
- cache stalls,
- multi-cycle multiply/divide (MDU) occupancy,
- load-use hazards,
- branch mispredictions.

It also sequences the MDU start/done handshake and discards stale fetches after a redirect.

---
 rtl/pipeline_ctrl_pkg.sv | 21 ++
 rtl/pipeline_ctrl_if.sv | 54 +++++
 rtl/pipeline_ctrl_load_use_detect.sv | 25 ++
 rtl/pipeline_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_types : shared types and constants for the rv32i pipeline control.
//   mdu_state_t  - MDU start/done handshake sequencer states
//   PERF_CNT_MAX - saturation value of the performance counters
//   perf_sat_inc - saturating increment used by the counters
// ---------------------------------------------------------------------------
package rv32i_types;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_HOLD = 2'd2
  } mdu_state_t;

  localparam logic [31:0] PERF_CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] perf_sat_inc(input logic [31:0] v);
    return (v == PERF_CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if : bundle of hazard inputs and latch controls between the
// pipeline datapath and pipeline_ctrl.
//   *_i signals : hazard/status inputs to the controller
//   *_o signals : latch enables, bubble inserts, MDU start, perf counters
//   modport slave  : the controller side
//   modport master : the datapath (or bench) side
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if;
  logic        imem_stall_i;
  logic        dmem_stall_i;
  logic        ex_valid_i;
  logic        ex_is_load_i;
  logic [4:0]  ex_rd_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_uses_rs1_i;
  logic        id_uses_rs2_i;
  logic        ex_mdu_req_i;
  logic        mdu_done_i;
  logic        ex_mispredict_i;

  logic        mdu_start_o;
  logic        load_pc_o;
  logic        load_if_id_o;
  logic        load_id_ex_o;
  logic        load_ex_mem_o;
  logic        load_mem_wb_o;
  logic        bubble_if_id_o;
  logic        bubble_id_ex_o;
  logic        bubble_ex_mem_o;
  logic [31:0] perf_dmem_stall_o;
  logic [31:0] perf_mdu_stall_o;
  logic [31:0] perf_load_use_o;
  logic [31:0] perf_flush_o;

  modport slave (
    input  imem_stall_i, dmem_stall_i, ex_valid_i, ex_is_load_i, ex_rd_i,
           id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i, ex_mdu_req_i,
           mdu_done_i, ex_mispredict_i,
    output mdu_start_o, load_pc_o, load_if_id_o, load_id_ex_o, load_ex_mem_o,
           load_mem_wb_o, bubble_if_id_o, bubble_id_ex_o, bubble_ex_mem_o,
           perf_dmem_stall_o, perf_mdu_stall_o, perf_load_use_o, perf_flush_o
  );

  modport master (
    output imem_stall_i, dmem_stall_i, ex_valid_i, ex_is_load_i, ex_rd_i,
           id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i, ex_mdu_req_i,
           mdu_done_i, ex_mispredict_i,
    input  mdu_start_o, load_pc_o, load_if_id_o, load_id_ex_o, load_ex_mem_o,
           load_mem_wb_o, bubble_if_id_o, bubble_id_ex_o, bubble_ex_mem_o,
           perf_dmem_stall_o, perf_mdu_stall_o, perf_load_use_o, perf_flush_o
  );
endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect : combinational load-use hazard detection.
//   i_ex_valid, i_ex_is_load, i_ex_rd : load currently in EX
//   i_id_rs1/2, i_id_uses_rs1/2       : sources read by the ID instruction
//   o_lu                              : ID needs a register the EX load writes
// ---------------------------------------------------------------------------
module load_use_detect (
  input  logic       i_ex_valid,
  input  logic       i_ex_is_load,
  input  logic [4:0] i_ex_rd,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  output logic       o_lu
);
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
  // x0 is never written, so a load targeting it cannot create a hazard.
  assign o_lu = i_ex_valid && i_ex_is_load && (i_ex_rd != 5'd0) &&
                (w_rs1_hit || w_rs2_hit);
endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl : stall/flush scheduler for the five-stage rv32i pipeline.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (all outputs forced to 0)
//   bus  : pipeline_ctrl_if.slave - hazard inputs, latch load/bubble
//          controls, MDU start pulse and 32-bit performance counters.
// Priority: dcache stall > MDU stall > mispredict flush > load-use >
// icache stall > free run. Also sequences the MDU handshake and drops the
// stale fetch that returns after a redirect issued during an icache miss.
// Optional feature: define PIPE_CTRL_PERF_EN to build the saturating perf
// counters; otherwise the perf_* outputs are tied to 0.
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import rv32i_types::*;
(
  input  logic          clk,
  input  logic          rst,
  pipeline_ctrl_if.slave bus
);

  mdu_state_t r_mdu_state;
  mdu_state_t w_mdu_state_nxt;
  logic       r_drop_pending;
  logic       w_drop_nxt;

  logic w_lu;
  logic w_mdu_stall;
  logic w_flush;
  logic w_start;
  logic w_ld_pc, w_ld_if_id, w_ld_id_ex, w_ld_ex_mem, w_ld_mem_wb;
  logic w_bb_if_id, w_bb_id_ex, w_bb_ex_mem;

  load_use_detect u_lud (
    .i_ex_valid    (bus.ex_valid_i),
    .i_ex_is_load  (bus.ex_is_load_i),
    .i_ex_rd       (bus.ex_rd_i),
    .i_id_rs1      (bus.id_rs1_i),
    .i_id_rs2      (bus.id_rs2_i),
    .i_id_uses_rs1 (bus.id_uses_rs1_i),
    .i_id_uses_rs2 (bus.id_uses_rs2_i),
    .o_lu          (w_lu)
  );

  assign w_mdu_stall = ((r_mdu_state == MDU_IDLE) && bus.ex_mdu_req_i) ||
                       ((r_mdu_state == MDU_BUSY) && !bus.mdu_done_i);

  always_comb begin
    w_ld_pc         = 1'b0;
    w_ld_if_id      = 1'b0;
    w_ld_id_ex      = 1'b0;
    w_ld_ex_mem     = 1'b0;
    w_ld_mem_wb     = 1'b0;
    w_bb_if_id      = 1'b0;
    w_bb_id_ex      = 1'b0;
    w_bb_ex_mem     = 1'b0;
    w_start         = 1'b0;
    w_flush         = 1'b0;
    w_mdu_state_nxt = r_mdu_state;
    w_drop_nxt      = r_drop_pending;

    if (!rst) begin
      if (bus.dmem_stall_i) begin
        // whole pipeline frozen
      end else if (w_mdu_stall) begin
        w_ld_ex_mem = 1'b1;
        w_bb_ex_mem = 1'b1;
        w_ld_mem_wb = 1'b1;
      end else if (bus.ex_mispredict_i) begin
        // EX is advancing here, so the flush is taken in this cycle.
        w_flush     = 1'b1;
        w_ld_pc     = 1'b1;
        w_ld_if_id  = 1'b1;
        w_ld_id_ex  = 1'b1;
        w_ld_ex_mem = 1'b1;
        w_ld_mem_wb = 1'b1;
        w_bb_if_id  = 1'b1;
        w_bb_id_ex  = 1'b1;
      end else if (w_lu) begin
        w_ld_id_ex  = 1'b1;
        w_bb_id_ex  = 1'b1;
        w_ld_ex_mem = 1'b1;
        w_ld_mem_wb = 1'b1;
      end else if (bus.imem_stall_i) begin
        w_ld_if_id  = 1'b1;
        w_bb_if_id  = 1'b1;
        w_ld_id_ex  = 1'b1;
        w_ld_ex_mem = 1'b1;
        w_ld_mem_wb = 1'b1;
      end else begin
        w_ld_pc     = 1'b1;
        w_ld_if_id  = 1'b1;
        w_ld_id_ex  = 1'b1;
        w_ld_ex_mem = 1'b1;
        w_ld_mem_wb = 1'b1;
      end

      // The stale fetch is squashed only when IF/ID actually captures it;
      // while IF/ID holds, the flag waits.
      if (r_drop_pending && !bus.imem_stall_i && w_ld_if_id) begin
        w_bb_if_id = 1'b1;
        w_drop_nxt = 1'b0;
      end
      if (w_flush && bus.imem_stall_i)
        w_drop_nxt = 1'b1;

      unique case (r_mdu_state)
        MDU_IDLE: begin
          if (bus.ex_mdu_req_i && !bus.dmem_stall_i) begin
            w_start         = 1'b1;
            w_mdu_state_nxt = MDU_BUSY;
          end
        end
        MDU_BUSY: begin
          if (bus.mdu_done_i)
            w_mdu_state_nxt = w_ld_ex_mem ? MDU_IDLE : MDU_HOLD;
        end
        MDU_HOLD: begin
          if (w_ld_ex_mem)
            w_mdu_state_nxt = MDU_IDLE;
        end
        default: w_mdu_state_nxt = MDU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mdu_state    <= MDU_IDLE;
      r_drop_pending <= 1'b0;
    end else begin
      r_mdu_state    <= w_mdu_state_nxt;
      r_drop_pending <= w_drop_nxt;
    end
  end

  assign bus.mdu_start_o     = w_start;
  assign bus.load_pc_o       = w_ld_pc;
  assign bus.load_if_id_o    = w_ld_if_id;
  assign bus.load_id_ex_o    = w_ld_id_ex;
  assign bus.load_ex_mem_o   = w_ld_ex_mem;
  assign bus.load_mem_wb_o   = w_ld_mem_wb;
  assign bus.bubble_if_id_o  = w_bb_if_id;
  assign bus.bubble_id_ex_o  = w_bb_id_ex;
  assign bus.bubble_ex_mem_o = w_bb_ex_mem;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_dmem;
  logic [31:0] r_perf_mdu;
  logic [31:0] r_perf_lu;
  logic [31:0] r_perf_flush;
  logic        w_lu_win;

  assign w_lu_win = !bus.dmem_stall_i && !w_mdu_stall &&
                    !bus.ex_mispredict_i && w_lu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_dmem  <= '0;
      r_perf_mdu   <= '0;
      r_perf_lu    <= '0;
      r_perf_flush <= '0;
    end else begin
      if (bus.dmem_stall_i) r_perf_dmem  <= perf_sat_inc(r_perf_dmem);
      if (w_mdu_stall)      r_perf_mdu   <= perf_sat_inc(r_perf_mdu);
      if (w_lu_win)         r_perf_lu    <= perf_sat_inc(r_perf_lu);
      if (w_flush)          r_perf_flush <= perf_sat_inc(r_perf_flush);
    end
  end

  assign bus.perf_dmem_stall_o = r_perf_dmem;
  assign bus.perf_mdu_stall_o  = r_perf_mdu;
  assign bus.perf_load_use_o   = r_perf_lu;
  assign bus.perf_flush_o      = r_perf_flush;
`else
  assign bus.perf_dmem_stall_o = '0;
  assign bus.perf_mdu_stall_o  = '0;
  assign bus.perf_load_use_o   = '0;
  assign bus.perf_flush_o      = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl : directed bench for pipeline_ctrl.
// Inputs change 1 ns after the rising edge; the combinational controls are
// compared 3 ns later, well before the next edge. Control outputs are packed
// as {pc, if_id, id_ex, ex_mem, mem_wb, bb_if_id, bb_id_ex, bb_ex_mem, start}.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if bus ();

  pipeline_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [8:0] C_ZERO = 9'b00000_000_0;
  localparam logic [8:0] C_RUN  = 9'b11111_000_0;
  localparam logic [8:0] C_LU   = 9'b00111_010_0;
  localparam logic [8:0] C_MDUS = 9'b00011_001_1;
  localparam logic [8:0] C_MDUW = 9'b00011_001_0;
  localparam logic [8:0] C_FLSH = 9'b11111_110_0;
  localparam logic [8:0] C_IMEM = 9'b01111_100_0;
  localparam logic [8:0] C_DROP = 9'b11111_100_0;

  function automatic logic [8:0] ctl();
    return {bus.load_pc_o, bus.load_if_id_o, bus.load_id_ex_o,
            bus.load_ex_mem_o, bus.load_mem_wb_o, bus.bubble_if_id_o,
            bus.bubble_id_ex_o, bus.bubble_ex_mem_o, bus.mdu_start_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_stall_i    = 1'b0;
    bus.dmem_stall_i    = 1'b0;
    bus.ex_valid_i      = 1'b0;
    bus.ex_is_load_i    = 1'b0;
    bus.ex_rd_i         = 5'd0;
    bus.id_rs1_i        = 5'd0;
    bus.id_rs2_i        = 5'd0;
    bus.id_uses_rs1_i   = 1'b0;
    bus.id_uses_rs2_i   = 1'b0;
    bus.ex_mdu_req_i    = 1'b0;
    bus.mdu_done_i      = 1'b0;
    bus.ex_mispredict_i = 1'b0;
  endtask

  initial begin
    // ---- reset: outputs 0 even with a pending MDU request ----
    rst = 1'b1;
    idle_inputs();
    bus.ex_valid_i   = 1'b1;
    bus.ex_mdu_req_i = 1'b1;
    #3;
    chk("rst_ctl", 32'(ctl()), 32'(C_ZERO));
    chk("rst_state", 32'(dut.r_mdu_state), 32'(MDU_IDLE));
    chk("rst_perf", bus.perf_dmem_stall_o | bus.perf_mdu_stall_o |
                    bus.perf_load_use_o | bus.perf_flush_o, 32'h0);

    cyc(); rst = 1'b0; idle_inputs(); #3;
    chk("run_ctl", 32'(ctl()), 32'(C_RUN));

    // ---- load-use on rs2 ----
    cyc();
    bus.ex_valid_i = 1'b1; bus.ex_is_load_i = 1'b1; bus.ex_rd_i = 5'd5;
    bus.id_rs2_i = 5'd5; bus.id_uses_rs2_i = 1'b1; bus.id_rs1_i = 5'd3;
    #3;
    chk("lu_ctl", 32'(ctl()), 32'(C_LU));
    // same pattern, destination x0: no hazard
    cyc(); bus.ex_rd_i = 5'd0; bus.id_rs2_i = 5'd0; #3;
    chk("lu_x0_ctl", 32'(ctl()), 32'(C_RUN));
    // rs2 match but source unused: no hazard
    cyc(); bus.ex_rd_i = 5'd5; bus.id_rs2_i = 5'd5; bus.id_uses_rs2_i = 1'b0; #3;
    chk("lu_unused_ctl", 32'(ctl()), 32'(C_RUN));
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_lu", bus.perf_load_use_o, 32'd1);
`endif

    // ---- MDU: done arrives 4 cycles after start ----
    cyc(); idle_inputs(); bus.ex_valid_i = 1'b1; bus.ex_mdu_req_i = 1'b1; #3;
    chk("mdu_start_ctl", 32'(ctl()), 32'(C_MDUS));
    for (int i = 1; i <= 3; i++) begin
      cyc(); #3;
      chk("mdu_wait_ctl", 32'(ctl()), 32'(C_MDUW));
      chk("mdu_wait_state", 32'(dut.r_mdu_state), 32'(MDU_BUSY));
    end
    cyc(); bus.mdu_done_i = 1'b1; #3;
    chk("mdu_done_ctl", 32'(ctl()), 32'(C_RUN));
    cyc(); idle_inputs(); #3;
    chk("mdu_idle_state", 32'(dut.r_mdu_state), 32'(MDU_IDLE));
    chk("mdu_after_ctl", 32'(ctl()), 32'(C_RUN));
    // done outside BUSY is ignored
    cyc(); bus.mdu_done_i = 1'b1; #3;
    chk("stray_done_ctl", 32'(ctl()), 32'(C_RUN));
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_mdu", bus.perf_mdu_stall_o, 32'd4);
`endif

    // ---- MDU done under a 3-cycle dcache stall -> HOLD ----
    cyc(); idle_inputs(); bus.ex_valid_i = 1'b1; bus.ex_mdu_req_i = 1'b1; #3;
    chk("hold_start_ctl", 32'(ctl()), 32'(C_MDUS));
    cyc(); bus.mdu_done_i = 1'b1; bus.dmem_stall_i = 1'b1; #3;
    chk("hold_d1_ctl", 32'(ctl()), 32'(C_ZERO));
    for (int i = 2; i <= 3; i++) begin
      cyc(); bus.mdu_done_i = 1'b0; #3;
      chk("hold_dn_ctl", 32'(ctl()), 32'(C_ZERO));
      chk("hold_state", 32'(dut.r_mdu_state), 32'(MDU_HOLD));
    end
    cyc(); bus.dmem_stall_i = 1'b0; #3;
    chk("hold_release_ctl", 32'(ctl()), 32'(C_RUN));
    cyc(); idle_inputs(); #3;
    chk("hold_idle_state", 32'(dut.r_mdu_state), 32'(MDU_IDLE));
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_dmem", bus.perf_dmem_stall_o, 32'd3);
`endif

    // ---- mispredict during icache miss, fetch returns 2 cycles later ----
    cyc(); bus.ex_valid_i = 1'b1; bus.ex_mispredict_i = 1'b1;
    bus.imem_stall_i = 1'b1; #3;
    chk("mp_ctl", 32'(ctl()), 32'(C_FLSH));
    cyc(); bus.ex_mispredict_i = 1'b0; #3;
    chk("mp_wait_ctl", 32'(ctl()), 32'(C_IMEM));
    chk("mp_drop_set", 32'(dut.r_drop_pending), 32'd1);
    cyc(); bus.imem_stall_i = 1'b0; #3;
    chk("mp_return_ctl", 32'(ctl()), 32'(C_DROP));
    cyc(); #3;
    chk("mp_drop_clr", 32'(dut.r_drop_pending), 32'd0);
    chk("mp_after_ctl", 32'(ctl()), 32'(C_RUN));

    // ---- mispredict deferred by dcache stall ----
    cyc(); bus.ex_mispredict_i = 1'b1; bus.imem_stall_i = 1'b1;
    bus.dmem_stall_i = 1'b1; #3;
    chk("mp_defer_ctl", 32'(ctl()), 32'(C_ZERO));
    cyc(); bus.dmem_stall_i = 1'b0; bus.imem_stall_i = 1'b0; #3;
    chk("mp_defer_nodrop", 32'(dut.r_drop_pending), 32'd0);
    chk("mp_taken_ctl", 32'(ctl()), 32'(C_FLSH));

    // ---- MDU stall outranks mispredict, then flush when done ----
    cyc(); bus.ex_mdu_req_i = 1'b1; #3;
    chk("mp_mdu_ctl", 32'(ctl()), 32'(C_MDUS));
    cyc(); bus.mdu_done_i = 1'b1; #3;
    chk("mp_mdu_done_ctl", 32'(ctl()), 32'(C_FLSH));
    cyc(); idle_inputs(); #3;
    chk("mp_mdu_state", 32'(dut.r_mdu_state), 32'(MDU_IDLE));
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_flush", bus.perf_flush_o, 32'd3);
`else
    chk("perf_tied", bus.perf_dmem_stall_o | bus.perf_mdu_stall_o |
                     bus.perf_load_use_o | bus.perf_flush_o, 32'h0);
`endif

    // ---- reset while BUSY, later done is ignored ----
    cyc(); bus.ex_valid_i = 1'b1; bus.ex_mdu_req_i = 1'b1; #3;
    chk("rb_start_ctl", 32'(ctl()), 32'(C_MDUS));
    cyc(); rst = 1'b1; #3;
    chk("rb_rst_ctl", 32'(ctl()), 32'(C_ZERO));
    chk("rb_rst_state", 32'(dut.r_mdu_state), 32'(MDU_IDLE));
    cyc(); bus.mdu_done_i = 1'b1; #3;
    chk("rb_rst_done_ctl", 32'(ctl()), 32'(C_ZERO));
    cyc(); rst = 1'b0; bus.ex_mdu_req_i = 1'b0; #3;
    chk("rb_late_done_ctl", 32'(ctl()), 32'(C_RUN));
    cyc(); idle_inputs(); #3;
    chk("rb_state", 32'(dut.r_mdu_state), 32'(MDU_IDLE));

`ifdef PIPE_CTRL_PERF_EN
    // ---- counter saturation ----
    force dut.r_perf_dmem = 32'hFFFF_FFFE;
    #1;
    release dut.r_perf_dmem;
    bus.dmem_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    bus.dmem_stall_i = 1'b0;
    #3;
    chk("perf_sat", bus.perf_dmem_stall_o, 32'hFFFF_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
